// File: rtl/rsa_modexp_engine.sv
// RSA modular exponentiation (x^E or x^D mod N) using bit-serial Montgomery
// multiplication and a fixed square-and-always-multiply schedule.
module rsa_modexp_engine #(
    parameter int K    = 12,
    parameter int LOGK = 4,
    parameter int N    = 3551,
    parameter int R2   = 2292,
    parameter int E    = 5,
    parameter int D    = 1373
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         mode,
    input  logic [K-1:0] data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [K-1:0] data_out,
    output logic         err,
    output logic         busy
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CHECK = 3'd1;
    localparam logic [2:0] ST_MM    = 3'd2;
    localparam logic [2:0] ST_FIN   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [2:0] OP_TOMX = 3'd0;
    localparam logic [2:0] OP_TOM1 = 3'd1;
    localparam logic [2:0] OP_SQR  = 3'd2;
    localparam logic [2:0] OP_MUL  = 3'd3;
    localparam logic [2:0] OP_FROM = 3'd4;

    localparam logic [K-1:0]    N_K      = K'(N);
    localparam logic [K-1:0]    R2_K     = K'(R2);
    localparam logic [K-1:0]    E_K      = K'(E);
    localparam logic [K-1:0]    D_K      = K'(D);
    localparam logic [K-1:0]    ONE_K    = K'(1);
    localparam logic [K+1:0]    N_ACC    = {2'b00, N_K};
    localparam logic [LOGK-1:0] CNT_LAST = LOGK'(K);
    localparam logic [LOGK-1:0] BIT_TOP  = LOGK'(K - 1);
    localparam logic [LOGK-1:0] CNT_ONE  = LOGK'(1);
    localparam logic [LOGK-1:0] CNT_ZERO = LOGK'(0);

    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;
    logic [2:0]      r_op;
    logic [K-1:0]    r_x;
    logic [K-1:0]    r_exp;
    logic [K-1:0]    r_mb;
    logic [K-1:0]    r_a;
    logic [K-1:0]    r_mm_a;
    logic [K-1:0]    r_mm_b;
    logic [K+1:0]    r_acc;
    logic [LOGK-1:0] r_cnt;
    logic [LOGK-1:0] r_bit;
    logic            r_in_ready;
    logic            r_out_valid;
    logic [K-1:0]    r_data_out;
    logic            r_err;
    logic            r_busy;

    logic            w_accept;
    logic            w_mm_last;
    logic [K+1:0]    w_addend;
    logic [K+1:0]    w_sum;
    logic [K+1:0]    w_sum_n;
    logic [K+1:0]    w_acc_nxt;
    logic [K+1:0]    w_diff;
    logic [K-1:0]    w_res;
    logic [K-1:0]    w_a_upd;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign data_out  = r_data_out;
    assign err       = r_err;
    assign busy      = r_busy;

    // Montgomery step: add a_i*b, make even by adding N, halve; final cycle subtracts N once.
    always_comb begin
        w_accept  = in_valid & r_in_ready;
        w_mm_last = (r_cnt == CNT_LAST);
        w_addend  = r_mm_a[0] ? {2'b00, r_mm_b} : {(K+2){1'b0}};
        w_sum     = r_acc + w_addend;
        w_sum_n   = w_sum[0] ? (w_sum + N_ACC) : w_sum;
        w_acc_nxt = {1'b0, w_sum_n[K+1:1]};
        w_diff    = r_acc - N_ACC;
        w_res     = (r_acc >= N_ACC) ? w_diff[K-1:0] : r_acc[K-1:0];
        w_a_upd   = r_exp[K-1] ? w_res : r_a;
    end

    // Next-state decode for the transaction sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  w_state_nxt = w_accept ? ST_CHECK : ST_IDLE;
            ST_CHECK: w_state_nxt = (r_x >= N_K) ? ST_DONE : ST_MM;
            ST_MM:    w_state_nxt = (w_mm_last && (r_op == OP_FROM)) ? ST_FIN : ST_MM;
            ST_FIN:   w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = (r_out_valid & out_ready) ? ST_IDLE : ST_DONE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_TOMX;
            r_x         <= {K{1'b0}};
            r_exp       <= {K{1'b0}};
            r_mb        <= {K{1'b0}};
            r_a         <= {K{1'b0}};
            r_mm_a      <= {K{1'b0}};
            r_mm_b      <= {K{1'b0}};
            r_acc       <= {(K+2){1'b0}};
            r_cnt       <= CNT_ZERO;
            r_bit       <= CNT_ZERO;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_data_out  <= {K{1'b0}};
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt == ST_IDLE);
            r_busy     <= (w_state_nxt != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_x   <= data_in;
                        r_exp <= mode ? D_K : E_K;
                    end
                end
                ST_CHECK: begin
                    if (r_x >= N_K) begin
                        r_data_out  <= {K{1'b0}};
                        r_err       <= 1'b1;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_op   <= OP_TOMX;
                        r_mm_a <= r_x;
                        r_mm_b <= R2_K;
                        r_acc  <= {(K+2){1'b0}};
                        r_cnt  <= CNT_ZERO;
                    end
                end
                ST_MM: begin
                    if (!w_mm_last) begin
                        r_acc  <= w_acc_nxt;
                        r_mm_a <= r_mm_a >> 1;
                        r_cnt  <= r_cnt + CNT_ONE;
                    end else begin
                        r_acc <= {(K+2){1'b0}};
                        r_cnt <= CNT_ZERO;
                        // Each finished product is routed to its destination and seeds the next MM.
                        case (r_op)
                            OP_TOMX: begin
                                r_mb   <= w_res;
                                r_op   <= OP_TOM1;
                                r_mm_a <= ONE_K;
                                r_mm_b <= R2_K;
                            end
                            OP_TOM1: begin
                                r_a    <= w_res;
                                r_op   <= OP_SQR;
                                r_mm_a <= w_res;
                                r_mm_b <= w_res;
                                r_bit  <= BIT_TOP;
                            end
                            OP_SQR: begin
                                r_a    <= w_res;
                                r_op   <= OP_MUL;
                                r_mm_a <= w_res;
                                r_mm_b <= r_mb;
                            end
                            OP_MUL: begin
                                r_a    <= w_a_upd;
                                r_exp  <= r_exp << 1;
                                r_mm_a <= w_a_upd;
                                if (r_bit == CNT_ZERO) begin
                                    r_op   <= OP_FROM;
                                    r_mm_b <= ONE_K;
                                end else begin
                                    r_op   <= OP_SQR;
                                    r_mm_b <= w_a_upd;
                                    r_bit  <= r_bit - CNT_ONE;
                                end
                            end
                            OP_FROM: begin
                                r_a <= w_res;
                            end
                            default: begin
                                r_op <= OP_TOMX;
                            end
                        endcase
                    end
                end
                ST_FIN: begin
                    r_data_out  <= r_a;
                    r_err       <= 1'b0;
                    r_out_valid <= 1'b1;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_modexp_engine.sv
// Directed bench for rsa_modexp_engine: vector table plus backpressure,
// ignored-request and mid-operation reset sequences.
module tb_rsa_modexp_engine;

    localparam int LAT = 353;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        mode;
    logic [11:0] data_in;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] data_out;
    logic        err;
    logic        busy;

    int n_checks;
    int n_errors;

    typedef struct {
        logic        m;
        logic [11:0] din;
        logic [11:0] dout;
        logic        e;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    rsa_modexp_engine dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mode     (mode),
        .data_in  (data_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .data_out (data_out),
        .err      (err),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int modpow(input int b, input int ex);
        longint r;
        longint x;
        r = 1;
        x = b % 3551;
        for (int i = 11; i >= 0; i--) begin
            r = (r * r) % 3551;
            if (((ex >> i) & 1) == 1) r = (r * x) % 3551;
        end
        return int'(r);
    endfunction

    // Issue one request, count edges from accept to out_valid, optionally consume.
    task automatic run_req(input logic m, input logic [11:0] x, input bit consume,
                           output logic [11:0] res, output logic e, output int lat);
        bit ok;
        @(negedge clk);
        mode = m; data_in = x; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0; ok = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
        if (!ok) chk("timeout", 0, 1);
        res = data_out;
        e   = err;
        if (consume) begin
            @(negedge clk); out_ready = 1'b1;
            @(posedge clk); #1 out_ready = 1'b0;
        end
    endtask

    initial begin
        logic [11:0] res;
        logic [11:0] res2;
        logic        e;
        int          lat;
        bit          seen;

        n_checks = 0; n_errors = 0;
        vecs[0] = '{1'b0, 12'd2,    12'd32,  1'b0, LAT};
        vecs[1] = '{1'b0, 12'd3,    12'd243, 1'b0, LAT};
        vecs[2] = '{1'b1, 12'd32,   12'd2,   1'b0, LAT};
        vecs[3] = '{1'b1, 12'd243,  12'd3,   1'b0, LAT};
        vecs[4] = '{1'b0, 12'd0,    12'd0,   1'b0, LAT};
        vecs[5] = '{1'b1, 12'd0,    12'd0,   1'b0, LAT};
        vecs[6] = '{1'b0, 12'd1,    12'd1,   1'b0, LAT};
        vecs[7] = '{1'b1, 12'd1,    12'd1,   1'b0, LAT};
        vecs[8] = '{1'b0, 12'd3551, 12'd0,   1'b1, 1};
        vecs[9] = '{1'b1, 12'd4095, 12'd0,   1'b1, 1};

        rst_n = 1'b0; in_valid = 1'b0; mode = 1'b0; data_in = 12'd0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  int'(in_ready),  1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_data_out",  int'(data_out),  0);
        chk("rst_err",       int'(err),       0);
        chk("rst_busy",      int'(busy),      0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_req(vecs[i].m, vecs[i].din, 1'b1, res, e, lat);
            chk($sformatf("vec%0d_data", i), int'(res), int'(vecs[i].dout));
            chk($sformatf("vec%0d_err", i),  int'(e),   int'(vecs[i].e));
            chk($sformatf("vec%0d_lat", i),  lat,       vecs[i].lat);
        end

        run_req(1'b1, 12'd2959, 1'b1, res, e, lat);
        chk("rt_dec", int'(res), modpow(2959, 1373));
        run_req(1'b0, res, 1'b1, res2, e, lat);
        chk("rt_enc", int'(res2), 2959);

        // Backpressure with an ignored request pulse while busy.
        @(negedge clk);
        mode = 1'b0; data_in = 12'd2; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        chk("busy_mid", int'(busy), 1);
        chk("in_ready_mid", int'(in_ready), 0);
        @(negedge clk); mode = 1'b1; data_in = 12'd3; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        lat = 51; seen = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(posedge clk); #1;
            lat++;
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("bp_seen", int'(seen), 1);
        chk("bp_lat", lat, LAT);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            chk("bp_hold", int'({out_valid, in_ready, err, data_out}), int'({1'b1, 1'b0, 1'b0, 12'd32}));
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        chk("bp_release_valid", int'(out_valid), 0);
        chk("bp_release_ready", int'(in_ready), 1);
        run_req(1'b0, 12'd3, 1'b1, res, e, lat);
        chk("b2b_data", int'(res), 243);
        chk("b2b_lat", lat, LAT);

        // Reset in the middle of a decrypt.
        @(negedge clk);
        mode = 1'b1; data_in = 12'd32; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (99) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_in_ready",  int'(in_ready),  1);
        chk("mr_out_valid", int'(out_valid), 0);
        chk("mr_data_out",  int'(data_out),  0);
        chk("mr_err",       int'(err),       0);
        chk("mr_busy",      int'(busy),      0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("mr_abandoned", int'(seen), 0);
        run_req(1'b1, 12'd32, 1'b1, res, e, lat);
        chk("mr_fresh_data", int'(res), 2);
        chk("mr_fresh_err",  int'(e),   0);
        chk("mr_fresh_lat",  lat,       LAT);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
